timer_bus_arbiter: RTL

- Shares the single register port of the timer (2-bit word address, write enable, 32-bit write/read data) between two bus requesters, e.g. CPU core (port 0) and debug/DMA master (port 1).
- Serialises accesses through a 3-state FSM with round-robin or fixed-priority arbitration.
- Returns read data with a one-cycle ack pulse.
- Sits between the requesters and the timer's CLK_I-domain register interface; IRQ is not touched.

---
 rtl/timer_bus_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/timer_bus_arbiter.sv
// ---------------------------------------------------------------------------
// timer_bus_arbiter
//
// Shares the timer's single register port between two bus requesters
// (port 0: CPU core, port 1: debug/DMA master). One access is served at a
// time through a three-state sequence IDLE -> ACCESS -> RESP, so at most
// one access completes every three cycles. The timer's IRQ is not touched.
//
// Parameters:
//   DW        : data width of requester and timer data buses
//   FIXED_PRI : 0 = round-robin between ports, 1 = port 0 wins every tie
//
// Ports:
//   CLK_I            system clock, all state on the rising edge
//   RST_I            asynchronous reset, active low
//   REQx_I           port x request, held until ACKx_O is seen
//   WEx_I            port x write (1) / read (0)
//   ADDRx_I          port x timer word address (00 ctrl, 01 preset,
//                    10 count, 11 count alias)
//   DATx_I           port x write data
//   ACKx_O           port x one-cycle completion pulse
//   DATx_O           port x read data (last value captured for that port)
//   T_ADDR_O         address to timer
//   T_WE_O           write enable to timer (high only during ACCESS)
//   T_DAT_O          write data to timer
//   T_DAT_I          combinational read data from timer
// ---------------------------------------------------------------------------
module timer_bus_arbiter #(
    parameter int DW        = 32,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          REQ0_I,
    input  logic          WE0_I,
    input  logic [1:0]    ADDR0_I,
    input  logic [DW-1:0] DAT0_I,
    output logic          ACK0_O,
    output logic [DW-1:0] DAT0_O,
    input  logic          REQ1_I,
    input  logic          WE1_I,
    input  logic [1:0]    ADDR1_I,
    input  logic [DW-1:0] DAT1_I,
    output logic          ACK1_O,
    output logic [DW-1:0] DAT1_O,
    output logic [1:0]    T_ADDR_O,
    output logic          T_WE_O,
    output logic [DW-1:0] T_DAT_O,
    input  logic [DW-1:0] T_DAT_I
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          winner_q, winner_d;
    logic          lastGnt_q, lastGnt_d;
    logic          we_q, we_d;
    logic [1:0]    addr_q, addr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [DW-1:0] rdat0_q, rdat0_d;
    logic [DW-1:0] rdat1_q, rdat1_d;
    logic          pick1;

    // lastGnt resets to 1 so that port 0 wins the first tie in round-robin
    // mode. An access interrupted by reset is simply forgotten.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= IDLE;
            winner_q  <= 1'b0;
            lastGnt_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            dat_q     <= '0;
            rdat0_q   <= '0;
            rdat1_q   <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            lastGnt_q <= lastGnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            rdat0_q   <= rdat0_d;
            rdat1_q   <= rdat1_d;
        end
    end

    // Next-state logic. Port 1 wins when it is the only requester, or on a
    // tie in round-robin mode when port 0 was granted last. The winner's
    // command is latched in IDLE so later changes on its inputs are ignored.
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        lastGnt_d = lastGnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        rdat0_d   = rdat0_q;
        rdat1_d   = rdat1_q;
        pick1     = REQ1_I && (!REQ0_I || ((FIXED_PRI == 1'b0) && (lastGnt_q == 1'b0)));

        case (state_q)
            IDLE: begin
                if (REQ0_I || REQ1_I) begin
                    winner_d  = pick1;
                    lastGnt_d = pick1;
                    we_d      = pick1 ? WE1_I   : WE0_I;
                    addr_d    = pick1 ? ADDR1_I : ADDR0_I;
                    dat_d     = pick1 ? DAT1_I  : DAT0_I;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                // Reads capture the timer's combinational data on the
                // closing edge; writes leave the read register untouched.
                if (!we_q) begin
                    if (winner_q) begin
                        rdat1_d = T_DAT_I;
                    end else begin
                        rdat0_d = T_DAT_I;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registered state, so reset removes the
    // write enable and acks without waiting for a clock edge.
    assign T_WE_O   = (state_q == ACCESS) && we_q;
    assign T_ADDR_O = addr_q;
    assign T_DAT_O  = dat_q;
    assign ACK0_O   = (state_q == RESP) && !winner_q;
    assign ACK1_O   = (state_q == RESP) && winner_q;
    assign DAT0_O   = rdat0_q;
    assign DAT1_O   = rdat1_q;

endmodule
